// File: rtl/hit_detector.sv
// Strike detector for the drum voice: arms on a loud sample, tracks the peak
// magnitude over a short window, fires a one-cycle start with the peak as
// velocity, then locks out re-triggering. Also runs a peak-hold/decay
// envelope follower for metering.
module hit_detector #(
  parameter logic [7:0] THRESH      = 8'd24,
  parameter int         PEAK_WINDOW = 8,
  parameter int         LOCKOUT     = 64,
  parameter int         DECAY_SHIFT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic       start,
  output logic [7:0] velocity,
  output logic       busy,
  output logic [7:0] env_level
);

  localparam logic [7:0]  PW8  = 8'(PEAK_WINDOW);
  localparam logic [15:0] LK16 = 16'(LOCKOUT);

  typedef enum logic [1:0] {IDLE, RISE, LOCK} state_t;

  state_t      state, state_n;
  logic [7:0]  peak, peak_n;
  logic [7:0]  win_cnt, win_n;
  logic [15:0] lock_cnt, lock_n;
  logic [7:0]  vel_n, env_n;
  logic        start_n;
  logic [7:0]  mag, pk_max;

  // Offset-binary to magnitude; 0x00 folds to 128.
  always_comb begin
    mag = (sample >= 8'h80) ? (sample - 8'h80) : (8'h80 - sample);
  end

  // State and datapath registers; everything advances only via the comb block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      peak      <= '0;
      win_cnt   <= '0;
      lock_cnt  <= '0;
      start     <= 1'b0;
      velocity  <= '0;
      busy      <= 1'b0;
      env_level <= '0;
    end else begin
      state     <= state_n;
      peak      <= peak_n;
      win_cnt   <= win_n;
      lock_cnt  <= lock_n;
      start     <= start_n;
      velocity  <= vel_n;
      busy      <= (state_n != IDLE);
      env_level <= env_n;
    end
  end

  // Next-state, peak tracking, lockout counting and envelope follower.
  always_comb begin
    state_n = state;
    peak_n  = peak;
    win_n   = win_cnt;
    lock_n  = lock_cnt;
    vel_n   = velocity;
    start_n = 1'b0;
    env_n   = env_level;
    pk_max  = (mag > peak) ? mag : peak;

    if (sample_valid) begin
      env_n = (mag > env_level) ? mag : (env_level - (env_level >> DECAY_SHIFT));

      case (state)
        IDLE: begin
          if (mag >= THRESH) begin
            peak_n = mag;
            if (PEAK_WINDOW == 1) begin
              // Single-sample window: the arming sample is also the completing one.
              start_n = 1'b1;
              vel_n   = mag;
              lock_n  = '0;
              win_n   = '0;
              state_n = LOCK;
            end else begin
              win_n   = 8'd1;
              state_n = RISE;
            end
          end
        end
        RISE: begin
          peak_n = pk_max;
          win_n  = win_cnt + 8'd1;
          if (win_cnt + 8'd1 == PW8) begin
            start_n = 1'b1;
            vel_n   = pk_max;
            lock_n  = '0;
            win_n   = '0;
            state_n = LOCK;
          end
        end
        LOCK: begin
          // Release needs the full lockout plus one quiet sample; loud input holds LOCK.
          if (lock_cnt == LK16 && mag < THRESH) state_n = IDLE;
          else if (lock_cnt != LK16)            lock_n  = lock_cnt + 16'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Bench for hit_detector: directed scenarios plus random traffic, every cycle
// compared against a sample-history reference model.
module tb_hit_detector;

  localparam int TH = 24;
  localparam int PW = 8;
  localparam int LK = 64;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample;
  logic       start;
  logic [7:0] velocity;
  logic       busy;
  logic [7:0] env_level;

  int checks = 0;
  int errors = 0;
  int starts_seen = 0;

  // Reference model: mode 0 idle, 1 collecting window, 2 locked out.
  int m_mode, m_lock, m_vel, m_env, m_start;
  int win_q[$];

  hit_detector #(.THRESH(8'(TH)), .PEAK_WINDOW(PW), .LOCKOUT(LK), .DECAY_SHIFT(DS)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .start(start), .velocity(velocity), .busy(busy), .env_level(env_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int magf(input int s);
    return (s >= 128) ? s - 128 : 128 - s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lock = 0; m_vel = 0; m_env = 0; m_start = 0;
    win_q.delete();
  endtask

  task automatic model_step(input bit v, input int s);
    int m, mx;
    m_start = 0;
    if (!v) return;
    m = magf(s);
    if (m > m_env) m_env = m;
    else           m_env = m_env - (m_env >> DS);
    case (m_mode)
      0: if (m >= TH) begin win_q.delete(); win_q.push_back(m); m_mode = 1; end
      1: win_q.push_back(m);
      default: begin
        if (m_lock >= LK && m < TH) m_mode = 0;
        else if (m_lock < LK)       m_lock++;
      end
    endcase
    if (m_mode == 1 && win_q.size() == PW) begin
      mx = 0;
      foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
      m_vel = mx; m_start = 1; m_mode = 2; m_lock = 0;
    end
  endtask

  task automatic compare_all();
    chk("start",     int'(start),     m_start);
    chk("velocity",  int'(velocity),  m_vel);
    chk("busy",      int'(busy),      int'(m_mode != 0));
    chk("env_level", int'(env_level), m_env);
  endtask

  // One clock: apply inputs, advance model, compare just after the edge.
  task automatic step(input bit v, input int s);
    sample_valid = v;
    sample       = 8'(s);
    @(posedge clk);
    model_step(v, s);
    #1;
    if (start) starts_seen++;
    compare_all();
  endtask

  task automatic steps(input int n, input int s);
    for (int i = 0; i < n; i++) step(1'b1, s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int st_list[10];
    int base;
    sample_valid = 1'b0;
    sample       = 8'h80;
    reset        = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_start", int'(start), 0);
    chk("rst_busy",  int'(busy),  0);

    // Single strike.
    st_list = '{8'h90, 8'hA0, 8'hC0, 8'hF0, 8'hD0, 8'hB0, 8'h90, 8'h88, 8'h84, 8'h80};
    steps(4, 8'h80);
    step(1'b1, st_list[0]);
    chk("no_arm_16", int'(busy), 0);
    step(1'b1, st_list[1]);
    chk("arm_busy", int'(busy), 1);
    for (int i = 2; i < 9; i++) step(1'b1, st_list[i]);
    chk("strike_start", int'(start), 1);
    chk("strike_vel", int'(velocity), 8'h70);
    step(1'b1, 8'h80);
    chk("start_one_cycle", int'(start), 0);
    steps(LK + 1, 8'h80);
    chk("released", int'(busy), 0);

    // Negative swing reaches full-scale velocity.
    step(1'b1, 8'h60);
    step(1'b1, 8'h00);
    steps(PW - 2, 8'h80);
    chk("neg_vel", int'(velocity), 128);
    chk("neg_start", int'(start), 1);
    steps(LK + 1, 8'h80);

    // Lockout: second burst inside lockout is ignored, later one fires.
    steps(PW, 8'hF0);
    base = starts_seen;
    steps(20, 8'h80);
    steps(5, 8'hF0);
    steps(70, 8'h80);
    chk("lock_ignored", starts_seen - base, 0);
    step(1'b1, 8'hF0);
    steps(PW - 2, 8'h80);
    chk("pre_retrig", int'(start), 0);
    step(1'b1, 8'h80);
    chk("retrig_start", int'(start), 1);
    // Loud signal past lockout keeps LOCK.
    steps(80, 8'hF0);
    chk("hold_busy", int'(busy), 1);
    step(1'b1, 8'h80);
    chk("hold_release", int'(busy), 0);

    // Valid gaps: same strike with 3 idle cycles between samples.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, st_list[i]);
      if (i < 8) for (int g = 0; g < 3; g++) step(1'b0, $urandom_range(0, 255));
    end
    chk("gap_start", int'(start), 1);
    chk("gap_vel", int'(velocity), 8'h70);
    step(1'b0, 8'hFF);
    chk("gap_start_fall", int'(start), 0);

    // Envelope decay from full reset.
    do_reset();
    step(1'b1, 8'hFF);
    chk("env0", int'(env_level), 127);
    step(1'b1, 8'h80);
    chk("env1", int'(env_level), 112);
    step(1'b1, 8'h80);
    chk("env2", int'(env_level), 98);
    step(1'b1, 8'h80);
    chk("env3", int'(env_level), 86);

    // Reset mid-RISE, then a fresh strike.
    do_reset();
    step(1'b1, 8'hA0);
    step(1'b1, 8'hC0);
    step(1'b1, 8'hF0);
    do_reset();
    chk("midrise_busy", int'(busy), 0);
    chk("midrise_vel", int'(velocity), 0);
    step(1'b1, 8'hA0);
    steps(PW - 1, 8'h90);
    chk("fresh_vel", int'(velocity), 8'h20);
    chk("fresh_start", int'(start), 1);

    // Random traffic: mostly near-silence with occasional bursts.
    for (int n = 0; n < 4000; n++) begin
      int s;
      if ($urandom_range(0, 19) == 0) s = $urandom_range(0, 255);
      else                            s = 128 + $urandom_range(0, 40) - 20;
      step($urandom_range(0, 3) != 0, s);
      if (n == 2000) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_detector.md
# hit_detector

Front-end trigger block for the drum voice. It consumes the 8-bit offset-binary sample stream from the ADC/pickup path (0x80 = silence, same coding as the sine generator output) and detects strikes. For each strike it emits a one-cycle `start` pulse plus an 8-bit `velocity` (peak magnitude), which drive the envelope shaper's `start` input and amplitude scaling. It also produces a peak-hold/decay envelope-follower level for metering.

## Interface
Parameters:
- `THRESH`, 8'd24: magnitude at or above which a strike is armed (valid 1..128).
- `PEAK_WINDOW`, 8: number of valid samples over which the peak is tracked, counting the arming sample (valid 1..255).
- `LOCKOUT`, 64: minimum number of valid samples after a strike before re-arming (valid 1..65535).
- `DECAY_SHIFT`, 3: envelope-follower decay, `level -= level >> DECAY_SHIFT` per valid sample (valid 1..7).

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `sample_valid`, in, 1: qualifies `sample`. All counting and tracking advances only on cycles where this is 1.
- `sample`, in, 8: offset-binary audio sample.
- `start`, out, 1: registered, one-cycle strike pulse.
- `velocity`, out, 8: peak magnitude of the last strike (0..128). Held until the next strike.
- `busy`, out, 1: registered, 1 whenever the state is not IDLE.
- `env_level`, out, 8: envelope-follower level (0..128).

## Operation
- Magnitude, computed combinationally and 8 bits wide: `mag = sample - 0x80` if `sample >= 0x80`, otherwise `0x80 - sample`. Range 0..128; 0x00 maps to 128.
- States: IDLE, RISE, LOCK.
- In IDLE:
  - On a valid sample with `mag >= THRESH`: go to RISE, `peak <= mag`, `win_cnt <= 1`.
  - If `PEAK_WINDOW == 1`, the strike completes on this same sample (see the completion rule below).
- In RISE, on each valid sample: `peak <= max(peak, mag)` and `win_cnt <= win_cnt + 1`.
- Strike completion: the valid sample that brings `win_cnt` to `PEAK_WINDOW` completes the strike. At that edge:
  - `start <= 1`.
  - `velocity <= max(peak, mag)`.
  - `lock_cnt <= 0`.
  - Go to LOCK.
- In LOCK, on each valid sample: `lock_cnt` increments, saturating at `LOCKOUT`. Return to IDLE only when, on a valid sample, `lock_cnt` has already reached `LOCKOUT` and `mag < THRESH`. A sustained loud signal therefore holds LOCK indefinitely. Strikes during LOCK are ignored and there is no retrigger.
- Envelope follower, independent of the FSM, on each valid sample:
  - If `mag > env_level`: `env_level <= mag`.
  - Otherwise: `env_level <= env_level - (env_level >> DECAY_SHIFT)`.
  - Truncating shift, so a nonzero level below `2^DECAY_SHIFT` stays constant. This is accepted.
- Invalid cycles (`sample_valid == 0`) change no state, counter, peak or level. `start` still falls.

## Timing
- Reset values:
  - `start = 0`, `velocity = 0`, `busy = 0`, `env_level = 0`.
  - Internal: state IDLE, `peak = 0`, `win_cnt = 0`, `lock_cnt = 0`.
- Reset mid-RISE or mid-LOCK aborts immediately. No `start` is emitted for the aborted strike.
- Latency: `start` and `velocity` update at the same clock edge that accepts the completing sample, so they are visible in the following cycle. `start` is high for exactly one cycle.
- The completing sample is accepted at an edge with the state still in RISE. `busy` remains 1 through LOCK.
- `busy` rises at the edge accepting the arming sample and falls at the edge accepting the releasing sample.
- Minimum spacing between two `start` pulses: `PEAK_WINDOW + LOCKOUT + 1` valid samples. A re-arm needs at least one below-threshold sample after the lockout expires, then the next arming sample.
- Back-to-back `sample_valid` on every cycle is supported. There is no backpressure.

## Test plan
- Single strike (defaults): 0x80 ×4, then 0x90 (mag 16, no arm), 0xA0, 0xC0, 0xF0, 0xD0, 0xB0, 0x90, 0x88, 0x84 -> arm on 0xA0; `start` for one cycle after 0x84; `velocity` = 0x70; `busy` = 1 from 0xA0 onward.
- Negative swing: arming sample 0x60 followed by 0x00 within the window -> `velocity` = 128 (0x80).
- Lockout: a strike, then a second 0xF0 burst 20 samples later -> no second `start`. Then 70 samples of 0x80, then 0xF0 -> a second `start` 8 valid samples after that 0xF0. Also hold 0xF0 past `LOCKOUT` -> `busy` stays 1.
- Valid gaps: repeat the single-strike stimulus with `sample_valid` low on 3 cycles between each sample -> identical `velocity`; `start` delayed only by the gap cycles.
- Envelope decay: one 0xFF sample, then 0x80 -> `env_level` sequence 127, 112, 98, 86.
- Reset mid-RISE: assert `reset` after the third window sample -> all outputs 0 next cycle. After release, a new strike gives a correct `velocity` with no stale peak.
